// File: rtl/aes_dec_iter_if.sv
// Handshake and data bundle between the iterative AES-128 decryptor and its environment.
interface aes_dec_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;

  // Environment side: offers ciphertext, serves round keys, consumes plaintext.
  modport master (
    output in_valid, ct_in, rk, out_ready,
    input  in_ready, rk_idx, out_valid, pt_out, busy
  );

  // Core side.
  modport slave (
    input  in_valid, ct_in, rk, out_ready,
    output in_ready, rk_idx, out_valid, pt_out, busy
  );
endinterface

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, one block in flight.
// Optional feature: define AES_DEC_ABORT_EN to add an abort input that drops the block.
module aes_dec_iter (
  input logic clk,
  input logic rst,
`ifdef AES_DEC_ABORT_EN
  input logic abort,
`endif
  aes_dec_iter_if.slave bus
);

  localparam int unsigned NumBytes  = 16;
  localparam int unsigned NumCols   = 4;
  localparam logic [3:0]  LastRound = 4'd9;
  localparam logic [3:0]  IdleKey   = 4'd10;

  localparam logic [7:0] InvSboxTable [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Round = 2'd1,
    Done  = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column times {0e,0b,0d,09} circulant; bits [31:24] are row 0.
  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*(3-i) +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_e       stateQ, stateD;
  logic [3:0]   rndQ, rndD;
  logic [127:0] dataQ, dataD;
  logic [127:0] ptQ, ptD;
  logic         outValidQ, outValidD;
  logic         inReadyQ, inReadyD;
  logic         busyQ, busyD;
  logic [3:0]   rkIdxQ, rkIdxD;
  logic [127:0] shifted, subbed, keyed, mixed;
  logic         accept;
  logic         abortActive;

  assign accept = bus.in_valid && inReadyQ;

`ifdef AES_DEC_ABORT_EN
  assign abortActive = abort && (stateQ != Idle);
`else
  assign abortActive = 1'b0;
`endif

  // Inverse round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    for (int k = 0; k < NumBytes; k++) begin
      // Byte k sits at row k%4, column k/4; row i takes from column (c - i) mod 4.
      shifted[8*(15-k) +: 8] = dataQ[8*(15-((((k/4) + 4 - (k%4)) % 4)*4 + (k%4))) +: 8];
    end
    for (int k = 0; k < NumBytes; k++) begin
      subbed[8*(15-k) +: 8] = InvSboxTable[shifted[8*(15-k) +: 8]];
    end
    keyed = subbed ^ bus.rk;
    for (int c = 0; c < NumCols; c++) begin
      mixed[32*(3-c) +: 32] = invMixCol(keyed[32*(3-c) +: 32]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) stateQ <= Idle;
    else     stateQ <= stateD;
  end

  // FSM next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      Idle:    if (accept) stateD = Round;
      Round:   if (rndQ == 4'd0) stateD = Done;
      Done:    if (bus.out_ready) stateD = Idle;
      default: stateD = Idle;
    endcase
    if (abortActive) stateD = Idle;
  end

  // FSM output and datapath next values; every port output is registered from these.
  always_comb begin
    dataD     = dataQ;
    rndD      = rndQ;
    ptD       = ptQ;
    outValidD = outValidQ;
    unique case (stateQ)
      Idle: begin
        if (accept) begin
          dataD = bus.ct_in ^ bus.rk;
          rndD  = LastRound;
        end
      end
      Round: begin
        if (rndQ != 4'd0) begin
          dataD = mixed;
          rndD  = rndQ - 4'd1;
        end else begin
          ptD       = keyed;
          outValidD = 1'b1;
        end
      end
      Done: begin
        if (bus.out_ready) outValidD = 1'b0;
      end
      default: ;
    endcase
    if (abortActive) begin
      ptD       = ptQ;
      outValidD = 1'b0;
      rndD      = '0;
    end
    inReadyD = (stateD == Idle);
    busyD    = (stateD != Idle);
    rkIdxD   = (stateD == Round) ? rndD : IdleKey;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataQ     <= '0;
      rndQ      <= '0;
      ptQ       <= '0;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      busyQ     <= 1'b0;
      rkIdxQ    <= IdleKey;
    end else begin
      dataQ     <= dataD;
      rndQ      <= rndD;
      ptQ       <= ptD;
      outValidQ <= outValidD;
      inReadyQ  <= inReadyD;
      busyQ     <= busyD;
      rkIdxQ    <= rkIdxD;
    end
  end

  assign bus.in_ready  = inReadyQ;
  assign bus.out_valid = outValidQ;
  assign bus.pt_out    = ptQ;
  assign bus.busy      = busyQ;
  assign bus.rk_idx    = rkIdxQ;

endmodule
